itcm_dump_tx: RTL

Serial memory dump transmitter for the FPGA top. On a start pulse it reads a run of 32-bit words from the ITCM/RAM through a synchronous read port and sends each word MSB byte first over an 8N1 UART line. The byte order matches the program-load path, which assembles words by shifting bytes in MSB first. An end marker word can be appended, so a captured dump can be fed straight back into the program loader.

---
 rtl/itcm_dump_tx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/itcm_dump_tx.sv
// itcm_dump_tx
//   Memory dump transmitter. On start_i it reads word_cnt_i 32-bit words from a
//   synchronous-read memory, beginning at base_addr_i. Each word goes out MSB
//   byte first on an 8N1 UART line, so the byte stream matches the program
//   loader's word assembly. When SEND_MARKER is set, END_MARKER follows the
//   data so that a captured dump can be replayed straight into the loader.
//
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   baud_div_i     clocks per UART bit; values below 2 are raised to 2; latched on start
//   start_i        one-cycle start request; only honoured while idle
//   base_addr_i    first word address; latched on start
//   word_cnt_i     number of data words, 0 .. 2^ADDR_WIDTH; latched on start
//   mem_addr_o     memory word address; holds its value while idle
//   mem_rd_o       read strobe; mem_rdata_i is valid the following cycle
//   mem_rdata_i    memory read data
//   tx_o           UART output; idles high
//   busy_o         high from the cycle after start until the done cycle
//   done_o         one-cycle completion pulse
//   words_sent_o   data words fully transmitted in the current or last dump
module itcm_dump_tx #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] END_MARKER  = 32'hFFFF_FFFF,
    parameter bit          SEND_MARKER = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [19:0]           baud_div_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   word_cnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   words_sent_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [19:0]           DIV_MIN  = 20'd2;
    localparam logic [19:0]           DIV_ONE  = 20'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPTURE, S_START, S_DATA, S_STOP, S_NEXT, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH:0]   sent_q, sent_d;
    logic                  marker_sent_q, marker_sent_d;
    logic                  data_word_q, data_word_d;  // word register holds a memory word, not the marker
    logic [31:0]           word_q, word_d;
    logic [19:0]           div_q, div_d;
    logic [19:0]           cnt_q, cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;

    logic                  tick;
    logic [ADDR_WIDTH:0]   rem_after;
    logic                  load_marker;
    logic [7:0]            cur_byte;

    // The current bit period ends when the down-counter reaches zero.
    assign tick     = (cnt_q == 20'd0);
    assign cur_byte = word_q[31:24];

    // Words still to fetch once the word just sent has been accounted for.
    always_comb begin
        rem_after   = data_word_q ? (rem_q - CNT_ONE) : rem_q;
        load_marker = (state_q == S_NEXT) && (rem_after == '0) &&
                      SEND_MARKER && !marker_sent_q;
    end

    // State register and control flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            sent_q        <= '0;
            marker_sent_q <= 1'b0;
            data_word_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            sent_q        <= sent_d;
            marker_sent_q <= marker_sent_d;
            data_word_q   <= data_word_d;
        end
    end

    // Datapath flops; every one is reloaded before use, so no reset is needed
    always_ff @(posedge clock) begin
        word_q     <= word_d;
        div_q      <= div_d;
        cnt_q      <= cnt_d;
        bit_idx_q  <= bit_idx_d;
        byte_idx_q <= byte_idx_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                // A zero-length dump goes through NEXT, which either loads the marker or finishes.
                if (start_i) state_d = (word_cnt_i != '0) ? S_FETCH : S_NEXT;
            end
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_START;
            S_START:   if (tick) state_d = S_DATA;
            S_DATA:    if (tick && (bit_idx_q == 3'd7)) state_d = S_STOP;
            S_STOP: begin
                if (tick) state_d = (byte_idx_q == 2'd3) ? S_NEXT : S_START;
            end
            S_NEXT: begin
                if (rem_after != '0) state_d = S_FETCH;
                else if (load_marker) state_d = S_START;
                else state_d = S_FINISH;
            end
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        addr_d        = addr_q;
        rem_d         = rem_q;
        sent_d        = sent_q;
        marker_sent_d = marker_sent_q;
        data_word_d   = data_word_q;
        word_d        = word_q;
        div_d         = div_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        byte_idx_d    = byte_idx_q;

        // Inside a bit the counter runs down. Elsewhere it is preloaded, so the next start bit gets a full period.
        if ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP))
            cnt_d = tick ? (div_q - DIV_ONE) : (cnt_q - DIV_ONE);
        else
            cnt_d = div_q - DIV_ONE;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d        = base_addr_i;
                    rem_d         = word_cnt_i;
                    div_d         = (baud_div_i < DIV_MIN) ? DIV_MIN : baud_div_i;
                    sent_d        = '0;
                    marker_sent_d = 1'b0;
                    data_word_d   = 1'b0;
                end
            end
            S_CAPTURE: begin
                word_d      = mem_rdata_i;
                data_word_d = 1'b1;
                bit_idx_d   = 3'd0;
                byte_idx_d  = 2'd0;
            end
            S_DATA: begin
                if (tick) bit_idx_d = bit_idx_q + 3'd1;
            end
            S_STOP: begin
                if (tick) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = {word_q[23:0], 8'h00};
                end
            end
            S_NEXT: begin
                if (data_word_q) begin
                    sent_d = sent_q + CNT_ONE;
                    addr_d = addr_q + ADDR_ONE;
                    rem_d  = rem_after;
                end
                data_word_d = 1'b0;
                bit_idx_d   = 3'd0;
                byte_idx_d  = 2'd0;
                if (load_marker) begin
                    word_d        = END_MARKER;
                    marker_sent_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd_o     = (state_q == S_FETCH);
        busy_o       = (state_q != S_IDLE) && (state_q != S_FINISH);
        done_o       = (state_q == S_FINISH);
        mem_addr_o   = addr_q;
        words_sent_o = sent_q;
        unique case (state_q)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = cur_byte[bit_idx_q];
            default: tx_o = 1'b1;
        endcase
    end

endmodule
